inst_mem_burst: RTL and testbench
=================================

// Module: inst_mem_burst
// PURPOSE
//  Line-fill engine between the instruction cache miss port and a synchronous BRAM.
//  Accepts a block-aligned fill request (mem_addr/mem_enable) and streams
//  BURST_LEN words back in order, one per cycle: mem_read_valid per word, mem_last on the final word.
//  Hides BRAM read latency through a pipelined valid/last shift chain.
// PARAMETERS
//  DATA_WIDTH         32  word width, both sides
//  ADDR_WIDTH         16  word address width, both sides
//  BLOCK_OFFSET_WIDTH 5   log2 words per line; BURST_LEN = 1<<BLOCK_OFFSET_WIDTH
//  READ_LATENCY       1   BRAM cycles from bram_en/bram_addr to valid bram_dout (>=1)
// PORTS
//  clk             in  1           system clock, rising edge
//  rst_n           in  1           asynchronous active-low reset
//  mem_addr        in  ADDR_WIDTH  fill base address from cache; valid while mem_enable=1
//  mem_enable      in  1           fill request level; held high by cache for the whole miss
//  mem_read        out DATA_WIDTH  fill data word (bram_dout passthrough)
//  mem_read_valid  out 1           mem_read holds the next sequential word of the line
//  mem_last        out 1           qualifies the final word; only high with mem_read_valid
//  bram_addr       out ADDR_WIDTH  BRAM read address (registered)
//  bram_en         out 1           BRAM read enable (registered)
//  bram_dout       in  DATA_WIDTH  BRAM read data, READ_LATENCY after bram_en
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; bram_en=0, bram_addr=0, issue_cnt=0,
//   valid/last pipe cleared -> mem_read_valid=0, mem_last=0. mem_read = bram_dout (X allowed).
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//  IDLE: mem_enable=1 -> latch base={mem_addr[ADDR_WIDTH-1:BOFS],BOFS'b0} (offset bits forced 0),
//   issue_cnt=0, -> ISSUE. Low offset bits of mem_addr ignored.
//  ISSUE: each cycle bram_en=1, bram_addr=base+issue_cnt; push valid=1, last=(issue_cnt==BURST_LEN-1)
//   into pipe; issue_cnt++. After issuing offset BURST_LEN-1 -> DRAIN. issue_cnt is
//   BLOCK_OFFSET_WIDTH+1 bits wide; no wrap into the next line.
//  DRAIN: bram_en=0; pipe shifts; when tail last=1 is emitted -> DONE.
//  DONE: mem_enable=1 -> stay (cache still high in mem_last cycle); mem_enable=0 -> IDLE.
//   A new request is never started off the same mem_enable level that produced mem_last.
//  Pipe: READ_LATENCY stages of {valid,last}; mem_read_valid/mem_last = tail stage.
//  Latency: mem_enable rises at cycle T (IDLE) -> bram_en first high at T+1 ->
//   first mem_read_valid at T+1+READ_LATENCY; then BURST_LEN consecutive valid cycles, no bubbles;
//   mem_last at T+READ_LATENCY+BURST_LEN. Words strictly in offset order 0..BURST_LEN-1.
//  Abort: mem_enable=0 in ISSUE or DRAIN -> next edge: clear pipe, bram_en=0, -> IDLE;
//   mem_read_valid=0 from that edge on; the partial line is never completed.
//  Back-to-back: earliest restart is the cycle after mem_enable is seen low (DONE->IDLE->ISSUE).
//  Reset mid-burst: all outputs return to reset values immediately; no valid after release
//   until a fresh request.
//  No backpressure: cache consumes every valid word in its cycle.
// STRUCTURE
//  Shared defines.v: state encodings (BURST_IDLE/ISSUE/DRAIN/DONE) as `define constants.
//  Sub-module: burst_valid_pipe (parameterised READ_LATENCY-deep shift register of
//   {valid,last}, async reset, synchronous flush input). Reused later for the data-cache fill path.
//  Top: FSM, base/issue_cnt registers, BRAM drive, pipe instance.
// TESTING
//  Bench: BRAM model with mem[a]=32'hA000_0000|a, configurable latency; drive like the cache.
//  1 Fill: READ_LATENCY=1, mem_enable=1 mem_addr=16'h0120 at T -> valid T+2..T+33,
//    data 0xA0000120..0xA000013F in order, mem_last only at T+33.
//  2 Latency: READ_LATENCY=3, mem_addr=16'h0040 -> first valid T+4, 32 consecutive, last T+35.
//  3 Misaligned: mem_addr=16'h0127 -> bram_addr starts 16'h0120; first word 0xA0000120.
//  4 Abort: drop mem_enable after 10 valid words -> mem_read_valid=0 from next edge,
//    bram_en=0, no mem_last; new request at 16'h0200 then streams cleanly.
//  5 Hold: keep mem_enable=1 3 cycles after mem_last -> no new bram_en; low 1 cycle, high -> refill.
//  6 Reset: rst_n=0 mid-burst (word 5) -> outputs 0 immediately; after release, idle until request.

Source files
------------

// File: rtl/inst_mem_burst_pkg.sv
// Shared types and default parameters for the instruction-cache line-fill engine.
package inst_mem_burst_pkg;

    typedef enum logic [1:0] {
        BURST_IDLE,
        BURST_ISSUE,
        BURST_DRAIN,
        BURST_DONE
    } burst_state_e;

    localparam int DEF_DATA_WIDTH         = 32;
    localparam int DEF_ADDR_WIDTH         = 16;
    localparam int DEF_BLOCK_OFFSET_WIDTH = 5;
    localparam int DEF_READ_LATENCY       = 1;

endpackage

// File: rtl/inst_mem_burst_if.sv
// Cache miss port plus BRAM read port of the line-fill engine.
// The slave modport is the engine's view; master is the cache/BRAM side.
interface inst_mem_burst_if
    import inst_mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_enable;
    logic [DATA_WIDTH-1:0] mem_read;
    logic                  mem_read_valid;
    logic                  mem_last;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport slave (
        input  mem_addr, mem_enable, bram_dout,
        output mem_read, mem_read_valid, mem_last, bram_addr, bram_en
    );

    modport master (
        output mem_addr, mem_enable, bram_dout,
        input  mem_read, mem_read_valid, mem_last, bram_addr, bram_en
    );
endinterface

// File: rtl/inst_mem_burst_valid_pipe.sv
// DEPTH-stage shift register of {valid,last} that tracks reads in flight
// through the BRAM; a synchronous flush drops everything in flight.
module burst_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last
);
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
        end else if (i_flush) begin
            // NOTE: flush outranks the shift so a word entering on the abort edge is dropped too.
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last & i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];
endmodule

// File: rtl/inst_mem_burst.sv
// Line-fill engine: turns one block-aligned miss into BURST_LEN sequential
// BRAM reads and streams the words back with valid/last aligned to the read latency.
module inst_mem_burst
    import inst_mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
    parameter int READ_LATENCY       = DEF_READ_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_burst_if.slave  bus
);
    localparam int BURST_LEN = 1 << BLOCK_OFFSET_WIDTH;
    localparam int CNT_W     = BLOCK_OFFSET_WIDTH + 1;
    localparam logic [CNT_W-1:0]      LAST_OFS = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BURST_LEN - 1);

    burst_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic                  r_bram_en;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic                  r_issue_last;

    logic                  w_abort;
    logic                  w_pipe_valid;
    logic                  w_pipe_last;
    logic [ADDR_WIDTH-1:0] w_line_base;

    assign w_line_base = bus.mem_addr & ~OFS_MASK;
    assign w_abort     = ((r_state == BURST_ISSUE) || (r_state == BURST_DRAIN)) && !bus.mem_enable;

    // Offset 0 is issued on the IDLE exit edge so bram_en rises the cycle after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BURST_IDLE;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_bram_en    <= 1'b0;
            r_bram_addr  <= '0;
            r_issue_last <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (r_state)
                BURST_IDLE: begin
                    r_bram_en    <= 1'b0;
                    r_issue_last <= 1'b0;
                    if (bus.mem_enable) begin
                        r_base       <= w_line_base;
                        r_bram_en    <= 1'b1;
                        r_bram_addr  <= w_line_base;
                        r_issue_last <= (BURST_LEN == 1);
                        r_issue_cnt  <= CNT_W'(1);
                        r_state      <= (BURST_LEN == 1) ? BURST_DRAIN : BURST_ISSUE;
                    end
                end
                BURST_ISSUE: begin
                    if (!bus.mem_enable) begin
                        r_bram_en    <= 1'b0;
                        r_issue_last <= 1'b0;
                        r_state      <= BURST_IDLE;
                    end else begin
                        r_bram_en    <= 1'b1;
                        r_bram_addr  <= r_base | ADDR_WIDTH'(r_issue_cnt[BLOCK_OFFSET_WIDTH-1:0]);
                        r_issue_last <= (r_issue_cnt == LAST_OFS);
                        r_issue_cnt  <= r_issue_cnt + CNT_W'(1);
                        if (r_issue_cnt == LAST_OFS) r_state <= BURST_DRAIN;
                    end
                end
                BURST_DRAIN: begin
                    r_bram_en    <= 1'b0;
                    r_issue_last <= 1'b0;
                    if (!bus.mem_enable)  r_state <= BURST_IDLE;
                    else if (w_pipe_last) r_state <= BURST_DONE;
                end
                BURST_DONE: begin
                    // Wait for the cache to drop its request before accepting another.
                    r_bram_en    <= 1'b0;
                    r_issue_last <= 1'b0;
                    if (!bus.mem_enable) r_state <= BURST_IDLE;
                end
                default: r_state <= BURST_IDLE;
            endcase
        end
    end

    burst_valid_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_valid (r_bram_en),
        .i_last  (r_issue_last),
        .o_valid (w_pipe_valid),
        .o_last  (w_pipe_last)
    );

    assign bus.bram_en        = r_bram_en;
    assign bus.bram_addr      = r_bram_addr;
    assign bus.mem_read       = bus.bram_dout;
    assign bus.mem_read_valid = w_pipe_valid;
    assign bus.mem_last       = w_pipe_last;
endmodule

// File: tb/tb_inst_mem_burst.sv
// Scoreboard bench for inst_mem_burst: one instance at read latency 1, one at 3,
// each behind a BRAM model returning 32'hA000_0000 | address.
module tb_inst_mem_burst;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    inst_mem_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if_a ();
    inst_mem_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if_b ();

    inst_mem_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5), .READ_LATENCY(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    inst_mem_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5), .READ_LATENCY(3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // BRAM models
    logic [31:0] bram_a_q;
    logic [31:0] bram_b_q [3];

    always @(posedge clk) begin
        bram_a_q    <= if_a.bram_en ? (32'hA000_0000 | 32'(if_a.bram_addr)) : 32'hDEAD_BEEF;
        bram_b_q[0] <= if_b.bram_en ? (32'hA000_0000 | 32'(if_b.bram_addr)) : 32'hDEAD_BEEF;
        bram_b_q[1] <= bram_b_q[0];
        bram_b_q[2] <= bram_b_q[1];
    end
    assign if_a.bram_dout = bram_a_q;
    assign if_b.bram_dout = bram_b_q[2];

    // Scoreboard
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_line(input bit b, input int t_first, input logic [15:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = t_first + k;
            e.data = 32'hA000_0000 | 32'(base + 16'(k));
            e.last = (k == 31);
            if (b) q_b.push_back(e);
            else   q_a.push_back(e);
        end
    endtask

    function automatic int q_size(input bit b);
        return b ? q_b.size() : q_a.size();
    endfunction

    function automatic exp_t q_pop(input bit b);
        return b ? q_b.pop_front() : q_a.pop_front();
    endfunction

    function automatic int q_front_cyc(input bit b);
        return b ? q_b[0].cyc : q_a[0].cyc;
    endfunction

    task automatic mon(input bit b, input logic v, input logic l, input logic [31:0] d);
        exp_t e;
        if (l && !v) check(b ? "b_last_without_valid" : "a_last_without_valid", v, 1'b1);
        if (v) begin
            if (q_size(b) == 0) begin
                check(b ? "b_unexpected_valid" : "a_unexpected_valid", v, 1'b0);
            end else begin
                e = q_pop(b);
                check(b ? "b_word_cycle" : "a_word_cycle", 64'(cyc), 64'(e.cyc));
                check(b ? "b_word_data" : "a_word_data", d, e.data);
                check(b ? "b_word_last" : "a_word_last", l, e.last);
            end
        end else if (q_size(b) != 0 && q_front_cyc(b) <= cyc) begin
            e = q_pop(b);
            check(b ? "b_missing_word" : "a_missing_word", v, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, if_a.mem_read_valid, if_a.mem_last, if_a.mem_read);
        mon(1'b1, if_b.mem_read_valid, if_b.mem_last, if_b.mem_read);
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic go_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input bit b, input logic [15:0] addr, output int t);
        @(posedge clk);
        #1;
        if (b) begin
            if_b.mem_addr   = addr;
            if_b.mem_enable = 1'b1;
        end else begin
            if_a.mem_addr   = addr;
            if_a.mem_enable = 1'b1;
        end
        t = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int budget;

        if_a.mem_addr   = '0;
        if_a.mem_enable = 1'b0;
        if_b.mem_addr   = '0;
        if_b.mem_enable = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", if_a.mem_read_valid, 1'b0);
        check("rst_last", if_a.mem_last, 1'b0);
        check("rst_bram_en", if_a.bram_en, 1'b0);
        check("rst_bram_addr", if_a.bram_addr, 16'h0000);
        check("rst_b_valid", if_b.mem_read_valid, 1'b0);
        rst_n = 1'b1;
        go_cycle(cyc + 3);

        // 1: plain fill, latency 1
        start(1'b0, 16'h0120, t);
        push_line(1'b0, t + 2, 16'h0120, 32);
        check("fill_idle_bram_en", if_a.bram_en, 1'b0);
        go_cycle(t + 1);
        check("fill_first_bram_en", if_a.bram_en, 1'b1);
        check("fill_first_bram_addr", if_a.bram_addr, 16'h0120);
        go_cycle(t + 32);
        check("fill_final_bram_addr", if_a.bram_addr, 16'h013F);

        // 5: hold mem_enable 3 cycles past mem_last, then re-request
        for (int c = t + 34; c <= t + 37; c++) begin
            go_cycle(c);
            check("hold_no_bram_en", if_a.bram_en, 1'b0);
        end
        if_a.mem_enable = 1'b0;
        go_cycle(t + 38);
        if_a.mem_addr   = 16'h0300;
        if_a.mem_enable = 1'b1;
        t2 = cyc;
        push_line(1'b0, t2 + 2, 16'h0300, 32);
        go_cycle(t2 + 1);
        check("refill_bram_addr", if_a.bram_addr, 16'h0300);
        go_cycle(t2 + 34);
        if_a.mem_enable = 1'b0;
        go_cycle(t2 + 36);

        // 2: read latency 3
        start(1'b1, 16'h0040, t);
        push_line(1'b1, t + 4, 16'h0040, 32);
        go_cycle(t + 36);
        if_b.mem_enable = 1'b0;
        go_cycle(t + 38);

        // 3: misaligned base is forced onto the line boundary
        start(1'b0, 16'h0127, t);
        push_line(1'b0, t + 2, 16'h0120, 32);
        go_cycle(t + 1);
        check("misaligned_bram_addr", if_a.bram_addr, 16'h0120);
        go_cycle(t + 2);
        check("misaligned_second_addr", if_a.bram_addr, 16'h0121);
        go_cycle(t + 34);
        if_a.mem_enable = 1'b0;
        go_cycle(t + 36);

        // 4: abort after 10 words, then a clean fill
        start(1'b0, 16'h0080, t);
        push_line(1'b0, t + 2, 16'h0080, 10);
        go_cycle(t + 11);
        if_a.mem_enable = 1'b0;
        go_cycle(t + 12);
        check("abort_bram_en", if_a.bram_en, 1'b0);
        check("abort_valid", if_a.mem_read_valid, 1'b0);
        go_cycle(t + 13);
        check("abort_bram_en_idle", if_a.bram_en, 1'b0);
        start(1'b0, 16'h0200, t2);
        push_line(1'b0, t2 + 2, 16'h0200, 32);
        go_cycle(t2 + 1);
        check("after_abort_bram_addr", if_a.bram_addr, 16'h0200);
        go_cycle(t2 + 34);
        if_a.mem_enable = 1'b0;
        go_cycle(t2 + 36);

        // 6: reset while word 5 is on the bus
        start(1'b0, 16'h0400, t);
        push_line(1'b0, t + 2, 16'h0400, 5);
        go_cycle(t + 7);
        check("pre_reset_valid", if_a.mem_read_valid, 1'b1);
        rst_n = 1'b0;
        if_a.mem_enable = 1'b0;
        #1;
        check("mid_reset_valid", if_a.mem_read_valid, 1'b0);
        check("mid_reset_last", if_a.mem_last, 1'b0);
        check("mid_reset_bram_en", if_a.bram_en, 1'b0);
        check("mid_reset_bram_addr", if_a.bram_addr, 16'h0000);
        go_cycle(t + 9);
        rst_n = 1'b1;
        go_cycle(t + 14);
        check("post_reset_idle_bram_en", if_a.bram_en, 1'b0);
        check("post_reset_idle_valid", if_a.mem_read_valid, 1'b0);
        start(1'b0, 16'h0500, t2);
        push_line(1'b0, t2 + 2, 16'h0500, 32);
        go_cycle(t2 + 34);
        if_a.mem_enable = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        budget = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        go_cycle(cyc + 2);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
